// File: rtl/store_result_monitor_if.sv
// ---------------------------------------------------------------------------
// store_result_monitor_if
//   Data-memory port of the core as seen by the store result monitor.
//   master : core side (drives strobes, address, store data; reads status)
//   slave  : monitor side (observes the core, returns registered status)
// Signals
//   MemWriteM    1   store strobe, valid this cycle
//   MemReadM     1   load strobe, valid this cycle
//   ALUResultM   32  load/store byte address
//   WriteDataM   32  store data
//   ReadDataMon  32  registered STATUS read data from the monitor
// ---------------------------------------------------------------------------
interface store_result_monitor_if;
    logic        MemWriteM;
    logic        MemReadM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataMon;

    modport master (
        output MemWriteM,
        output MemReadM,
        output ALUResultM,
        output WriteDataM,
        input  ReadDataMon
    );

    modport slave (
        input  MemWriteM,
        input  MemReadM,
        input  ALUResultM,
        input  WriteDataM,
        output ReadDataMon
    );
endinterface

// File: rtl/store_result_monitor.sv
// ---------------------------------------------------------------------------
// store_result_monitor
//   Watches the core's data-memory store port for the program's self-check
//   store to RESULT_ADDR and judges it against PASS_VALUE. A watchdog ends
//   the run if no result store arrives within TIMEOUT cycles. Status flags
//   are sticky until reset and readable as a word at STATUS_ADDR.
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low reset
//   bus          --   data-memory port (slave modport)
//   done         out  terminal state reached (pass, fail or timeout)
//   pass         out  result store matched PASS_VALUE
//   fail         out  result store mismatched, or timeout
//   timeout      out  watchdog expired before the result store
//   cycles       out  cycles spent running, saturating
//   store_count  out  stores accepted while running, saturating
//   result_data  out  store data captured at the result store
// STATUS word: {28'b0, timeout, fail, pass, done}
// ---------------------------------------------------------------------------
module store_result_monitor #(
    parameter logic [31:0] RESULT_ADDR = 32'd212,
    parameter logic [31:0] PASS_VALUE  = 32'd511,
    parameter int unsigned TIMEOUT     = 500,
    parameter logic [31:0] STATUS_ADDR = 32'd216,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    store_result_monitor_if.slave  bus,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout,
    output logic [CNT_W-1:0]       cycles,
    output logic [CNT_W-1:0]       store_count,
    output logic [31:0]            result_data
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2,
        ST_TMO  = 2'd3
    } state_e;

    // Value of the cycle counter during the last running cycle in which a
    // result store can still be accepted.
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] store_count_q, store_count_d;
    logic [31:0]      result_data_q, result_data_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      read_data_q, read_data_d;

    logic result_hit;
    logic status_hit;

    assign result_hit = bus.MemWriteM && (bus.ALUResultM == RESULT_ADDR);
    assign status_hit = bus.MemReadM  && (bus.ALUResultM == STATUS_ADDR);

    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_d       = state_q;
        cycles_d      = cycles_q;
        store_count_d = store_count_q;
        result_data_d = result_data_q;

        // Terminal states fall through with everything frozen.
        if (state_q == ST_RUN) begin
            if (cycles_q != '1) begin
                cycles_d = cycles_q + 1'b1;
            end
            if (bus.MemWriteM && (store_count_q != '1)) begin
                store_count_d = store_count_q + 1'b1;
            end
            // The result store is checked first so it wins over the
            // watchdog in the final allowed cycle.
            if (result_hit) begin
                result_data_d = bus.WriteDataM;
                state_d       = (bus.WriteDataM == PASS_VALUE) ? ST_PASS : ST_FAIL;
            end else if (cycles_q == LAST_CYCLE) begin
                state_d = ST_TMO;
            end
        end

        // Flags are registered from the next state so they appear the cycle
        // after the deciding edge, together with the state itself.
        done_d    = (state_d != ST_RUN);
        pass_d    = (state_d == ST_PASS);
        fail_d    = (state_d == ST_FAIL) || (state_d == ST_TMO);
        timeout_d = (state_d == ST_TMO);

        // Reads return the flags as they stand at the read edge.
        read_data_d = status_hit ? {28'b0, timeout_q, fail_q, pass_q, done_q} : 32'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    // NOTE: reset is sampled only at the clock edge (synchronous), so it
    // lives inside the clocked branch and overrides any strobe that cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            cycles_q      <= '0;
            store_count_q <= '0;
            result_data_q <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            read_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            cycles_q      <= cycles_d;
            store_count_q <= store_count_d;
            result_data_q <= result_data_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
            read_data_q   <= read_data_d;
        end
    end

    assign bus.ReadDataMon = read_data_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign fail            = fail_q;
    assign timeout         = timeout_q;
    assign cycles          = cycles_q;
    assign store_count     = store_count_q;
    assign result_data     = result_data_q;

endmodule

// File: tb/tb_store_result_monitor.sv
// ---------------------------------------------------------------------------
// tb_store_result_monitor
//   Drives the monitor through pass, fail, timeout and reset scenarios.
//   A reference model of the run state tracks every driven cycle; the
//   expected STATUS read word is queued when the cycle is driven and popped
//   when the registered read data appears after the edge.
// ---------------------------------------------------------------------------
module tb_store_result_monitor;

    localparam logic [31:0] RESULT_ADDR = 32'd212;
    localparam logic [31:0] PASS_VALUE  = 32'd511;
    localparam int unsigned TIMEOUT     = 500;
    localparam logic [31:0] STATUS_ADDR = 32'd216;
    localparam int unsigned CNT_W       = 16;

    typedef enum logic [1:0] {M_RUN, M_PASS, M_FAIL, M_TMO} m_state_e;

    logic             clk;
    logic             reset;
    logic             done, pass, fail, timeout;
    logic [CNT_W-1:0] cycles, store_count;
    logic [31:0]      result_data;

    store_result_monitor_if bus ();

    store_result_monitor #(
        .RESULT_ADDR (RESULT_ADDR),
        .PASS_VALUE  (PASS_VALUE),
        .TIMEOUT     (TIMEOUT),
        .STATUS_ADDR (STATUS_ADDR),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .cycles      (cycles),
        .store_count (store_count),
        .result_data (result_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model
    m_state_e    m_state  = M_RUN;
    int unsigned m_cycles = 0;
    logic [31:0] rd_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Drive one clock cycle, advance the model, and compare once the
    // registered outputs have settled after the edge.
    task automatic cyc(input logic rst_v, input logic we, input logic re,
                       input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] exp_rd;
        reset          = rst_v;
        bus.MemWriteM  = we;
        bus.MemReadM   = re;
        bus.ALUResultM = addr;
        bus.WriteDataM = data;

        if (rst_v && re && (addr == STATUS_ADDR)) begin
            exp_rd = {28'b0, m_state == M_TMO, (m_state == M_FAIL) || (m_state == M_TMO),
                      m_state == M_PASS, m_state != M_RUN};
        end else begin
            exp_rd = 32'b0;
        end
        rd_q.push_back(exp_rd);

        if (!rst_v) begin
            m_state  = M_RUN;
            m_cycles = 0;
        end else if (m_state == M_RUN) begin
            if (we && (addr == RESULT_ADDR)) begin
                m_state = (data == PASS_VALUE) ? M_PASS : M_FAIL;
            end else if (m_cycles == TIMEOUT - 1) begin
                m_state = M_TMO;
            end
            m_cycles++;
        end

        @(posedge clk);
        #1;
        check("read_data", bus.ReadDataMon, rd_q.pop_front());
        check("done_track", {31'b0, done}, {31'b0, m_state != M_RUN});
        check("cycles_track", {16'b0, cycles}, m_cycles);
        bus.MemWriteM = 1'b0;
        bus.MemReadM  = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic check_flags(input string tag, input logic d, input logic p,
                               input logic f, input logic t);
        check({tag, "_flags"}, {28'b0, timeout, fail, pass, done}, {28'b0, t, f, p, d});
    endtask

    initial begin
        reset          = 1'b0;
        bus.MemWriteM  = 1'b0;
        bus.MemReadM   = 1'b0;
        bus.ALUResultM = 32'd0;
        bus.WriteDataM = 32'd0;

        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_cycles", {16'b0, cycles}, 32'd0);
        check("reset_stores", {16'b0, store_count}, 32'd0);
        check("reset_result", result_data, 32'd0);

        // Passing result store in running cycle 40
        idle(39);
        check_flags("pre_pass", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, RESULT_ADDR, 32'd511);
        check_flags("pass", 1'b1, 1'b1, 1'b0, 1'b0);
        check("pass_result", result_data, 32'd511);
        check("pass_cycles", {16'b0, cycles}, 32'd40);
        check("pass_stores", {16'b0, store_count}, 32'd1);

        // Later stores are ignored; PASS reads back done|pass
        cyc(1'b1, 1'b1, 1'b0, RESULT_ADDR, 32'd0);
        check_flags("post_pass", 1'b1, 1'b1, 1'b0, 1'b0);
        check("post_pass_result", result_data, 32'd511);
        check("post_pass_stores", {16'b0, store_count}, 32'd1);
        check("post_pass_cycles", {16'b0, cycles}, 32'd40);
        cyc(1'b1, 1'b0, 1'b1, STATUS_ADDR, 32'd0);
        check("pass_status", bus.ReadDataMon, 32'h3);
        idle(1);
        check("status_clears", bus.ReadDataMon, 32'h0);

        // Failing run: six non-result stores, then the wrong value
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'd100, 32'd5);
        cyc(1'b1, 1'b1, 1'b1, STATUS_ADDR, 32'd9);
        cyc(1'b1, 1'b1, 1'b0, 32'd213, 32'd511);
        cyc(1'b1, 1'b1, 1'b0, 32'h1000_00D4, 32'd511);
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, STATUS_ADDR, 32'd1);
        check_flags("pre_fail", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, RESULT_ADDR, 32'd510);
        check_flags("fail", 1'b1, 1'b0, 1'b1, 1'b0);
        check("fail_result", result_data, 32'd510);
        check("fail_stores", {16'b0, store_count}, 32'd7);
        check("fail_cycles", {16'b0, cycles}, 32'd7);
        cyc(1'b1, 1'b0, 1'b1, STATUS_ADDR, 32'd0);
        check("fail_status", bus.ReadDataMon, 32'h5);

        // Reset after FAIL; the simultaneous result store must be dropped
        cyc(1'b0, 1'b1, 1'b0, RESULT_ADDR, 32'd511);
        check_flags("rst_fail", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_fail_stores", {16'b0, store_count}, 32'd0);
        check("rst_fail_result", result_data, 32'd0);
        check("rst_fail_cycles", {16'b0, cycles}, 32'd0);
        idle(1);
        check("restart_cycles", {16'b0, cycles}, 32'd1);
        check_flags("restart", 1'b0, 1'b0, 1'b0, 1'b0);

        // Watchdog: no result store within TIMEOUT running cycles
        idle(TIMEOUT - 2);
        check("pre_tmo_cycles", {16'b0, cycles}, TIMEOUT - 1);
        check_flags("pre_tmo", 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        check_flags("tmo", 1'b1, 1'b0, 1'b1, 1'b1);
        check("tmo_cycles", {16'b0, cycles}, TIMEOUT);
        cyc(1'b1, 1'b1, 1'b0, RESULT_ADDR, 32'd511);
        check_flags("post_tmo", 1'b1, 1'b0, 1'b1, 1'b1);
        check("post_tmo_result", result_data, 32'd0);
        check("post_tmo_stores", {16'b0, store_count}, 32'd0);
        idle(3);
        check("tmo_frozen", {16'b0, cycles}, TIMEOUT);
        cyc(1'b1, 1'b0, 1'b1, STATUS_ADDR, 32'd0);
        check("tmo_status", bus.ReadDataMon, 32'hD);

        // Result store in the last allowed cycle beats the watchdog
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(TIMEOUT - 1);
        check_flags("edge_pre", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, RESULT_ADDR, 32'd511);
        check_flags("edge_pass", 1'b1, 1'b1, 1'b0, 1'b0);
        check("edge_cycles", {16'b0, cycles}, TIMEOUT);
        check("edge_result", result_data, 32'd511);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
